// File: rtl/dshot_pkg.sv
// Shared types and constants for the DShot-to-PWM output stage.
package dshot_pkg;

   localparam int unsigned DSHOT_MIN_THROTTLE = 48;
   localparam int unsigned DSHOT_MAX_THROTTLE = 2047;
   localparam int unsigned DSHOT_CMD_DISARM   = 0;

   localparam int unsigned SPEED_W = 11;
   localparam int unsigned CMD_W   = 6;
   localparam int unsigned PULSE_W = 16;

   typedef logic [PULSE_W-1:0] pulse_t;
   typedef logic [SPEED_W-1:0] speed_t;
   typedef logic [CMD_W-1:0]   cmd_t;

   typedef enum logic [1:0] {
      ST_DISARMED = 2'd0,
      ST_ARMED    = 2'd1,
      ST_FAILSAFE = 2'd2
   } arm_state_e;

   // Throttle 48..2047 maps linearly onto min_pulse + steps of 2^step_shift clocks.
   function automatic pulse_t throttle_to_pulse(input speed_t     speed,
                                                input pulse_t     min_pulse,
                                                input int unsigned step_shift);
      pulse_t steps;
      steps = PULSE_W'(speed) - PULSE_W'(DSHOT_MIN_THROTTLE);
      return min_pulse + (steps << step_shift);
   endfunction

endpackage

// File: rtl/dshot_pwm_output_if.sv
// Decoded-frame bus from dshotInput into the PWM output stage.
interface dshot_pwm_output_if;
   import dshot_pkg::*;

   speed_t setSpeed;
   cmd_t   specialCommand;
   logic   isSpecialCommand;
   logic   isValidSpeed;
   logic   CRCValid;
   logic   processing;

   modport master (
      output setSpeed,
      output specialCommand,
      output isSpecialCommand,
      output isValidSpeed,
      output CRCValid,
      output processing
   );

   modport slave (
      input setSpeed,
      input specialCommand,
      input isSpecialCommand,
      input isValidSpeed,
      input CRCValid,
      input processing
   );

endinterface

// File: rtl/dshot_pwm_output_pwm_generator.sv
// Fixed-period PWM: width reloads only at period start so pulses are never cut or stretched.
module pwm_generator
   import dshot_pkg::*;
#(
   parameter int unsigned PERIOD_CLKS    = 320000,
   parameter int unsigned MIN_PULSE_CLKS = 16000
) (
   input  logic   clk,
   input  logic   rst,
   input  pulse_t target,
   output pulse_t pulseClks,
   output logic   pwmOut
);

   localparam int unsigned       CNT_W    = $clog2(PERIOD_CLKS);
   localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(PERIOD_CLKS - 1);
   localparam pulse_t            MIN_PULSE = PULSE_W'(MIN_PULSE_CLKS);

   logic [CNT_W-1:0] period_cnt_q, period_cnt_d;
   pulse_t           pulse_q, pulse_d;
   logic             pwm_q, pwm_d;

   // Compare against the width being loaded this edge so the first clock of a period is high.
   always_comb begin
      period_cnt_d = period_cnt_q;
      pulse_d      = pulse_q;
      pwm_d        = 1'b0;

      if (period_cnt_q == CNT_LAST) begin
         period_cnt_d = '0;
      end else begin
         period_cnt_d = period_cnt_q + CNT_W'(1);
      end

      if (period_cnt_q == '0) begin
         pulse_d = target;
      end

      pwm_d = (32'(period_cnt_q) < 32'(pulse_d));
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         period_cnt_q <= '0;
         pulse_q      <= MIN_PULSE;
         pwm_q        <= 1'b0;
      end else begin
         period_cnt_q <= period_cnt_d;
         pulse_q      <= pulse_d;
         pwm_q        <= pwm_d;
      end
   end

   assign pulseClks = pulse_q;
   assign pwmOut    = pwm_q;

endmodule

// File: rtl/dshot_pwm_output.sv
// DShot frame consumer: arming FSM, link-loss watchdog with latched failsafe, and servo PWM drive.
module dshot_pwm_output
   import dshot_pkg::*;
#(
   parameter int unsigned PERIOD_CLKS    = 320000,
   parameter int unsigned MIN_PULSE_CLKS = 16000,
   parameter int unsigned STEP_SHIFT     = 3,
   parameter int unsigned ARM_FRAMES     = 10,
   parameter int unsigned TIMEOUT_CLKS   = 1600000
) (
   input  logic               clk,
   input  logic               rst,
   dshot_pwm_output_if.slave  frame,
   output logic               pwmOut,
   output pulse_t             pulseClks,
   output logic               armed,
   output logic               failsafe
);

   localparam int unsigned      WD_W      = $clog2(TIMEOUT_CLKS);
   localparam int unsigned      ARM_W     = $clog2(ARM_FRAMES + 1);
   localparam logic [WD_W-1:0]  WD_LAST   = WD_W'(TIMEOUT_CLKS - 1);
   localparam logic [ARM_W-1:0] ARM_LAST  = ARM_W'(ARM_FRAMES - 1);
   localparam pulse_t           MIN_PULSE = PULSE_W'(MIN_PULSE_CLKS);

   logic             proc_dly_q, proc_dly_d;
   arm_state_e       state_q, state_d;
   logic [ARM_W-1:0] arm_cnt_q, arm_cnt_d;
   logic [WD_W-1:0]  wd_cnt_q, wd_cnt_d;
   pulse_t           target_q, target_d;
   logic             armed_q, armed_d;
   logic             failsafe_q, failsafe_d;

   logic strobe_c;
   logic valid_c;
   logic throttle_c;
   logic disarm_c;
   logic expire_c;

   // A frame is complete on the falling edge of processing.
   always_comb begin
      proc_dly_d = frame.processing;
      strobe_c   = proc_dly_q & ~frame.processing;
      valid_c    = strobe_c & frame.CRCValid;
      throttle_c = valid_c & frame.isValidSpeed;
      disarm_c   = valid_c & frame.isSpecialCommand &
                   (frame.specialCommand == CMD_W'(DSHOT_CMD_DISARM));
      expire_c   = (wd_cnt_q == WD_LAST) & ~valid_c;
   end

   always_comb begin
      state_d    = state_q;
      arm_cnt_d  = arm_cnt_q;
      wd_cnt_d   = wd_cnt_q;
      target_d   = target_q;
      armed_d    = armed_q;
      failsafe_d = failsafe_q;

      // Watchdog saturates at its last count so expiry stays asserted until a valid frame.
      if (valid_c) begin
         wd_cnt_d = '0;
      end else if (wd_cnt_q != WD_LAST) begin
         wd_cnt_d = wd_cnt_q + WD_W'(1);
      end

      case (state_q)
         ST_ARMED: begin
            if (expire_c) begin
               state_d    = ST_FAILSAFE;
               target_d   = MIN_PULSE;
               armed_d    = 1'b0;
               failsafe_d = 1'b1;
               arm_cnt_d  = '0;
            end else if (throttle_c) begin
               target_d = throttle_to_pulse(frame.setSpeed, MIN_PULSE, STEP_SHIFT);
            end else if (disarm_c) begin
               target_d = MIN_PULSE;
            end
         end

         // DISARMED and FAILSAFE share the arming sequence; failsafe clears only on arm.
         default: begin
            target_d = MIN_PULSE;
            if (expire_c || throttle_c) begin
               arm_cnt_d = '0;
            end else if (disarm_c) begin
               if (arm_cnt_q == ARM_LAST) begin
                  state_d    = ST_ARMED;
                  armed_d    = 1'b1;
                  failsafe_d = 1'b0;
                  arm_cnt_d  = '0;
               end else begin
                  arm_cnt_d = arm_cnt_q + ARM_W'(1);
               end
            end
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         proc_dly_q <= 1'b0;
         state_q    <= ST_DISARMED;
         arm_cnt_q  <= '0;
         wd_cnt_q   <= '0;
         target_q   <= MIN_PULSE;
         armed_q    <= 1'b0;
         failsafe_q <= 1'b0;
      end else begin
         proc_dly_q <= proc_dly_d;
         state_q    <= state_d;
         arm_cnt_q  <= arm_cnt_d;
         wd_cnt_q   <= wd_cnt_d;
         target_q   <= target_d;
         armed_q    <= armed_d;
         failsafe_q <= failsafe_d;
      end
   end

   pwm_generator #(
      .PERIOD_CLKS    (PERIOD_CLKS),
      .MIN_PULSE_CLKS (MIN_PULSE_CLKS)
   ) u_pwm (
      .clk       (clk),
      .rst       (rst),
      .target    (target_q),
      .pulseClks (pulseClks),
      .pwmOut    (pwmOut)
   );

   assign armed    = armed_q;
   assign failsafe = failsafe_q;

endmodule

// File: tb/tb_dshot_pwm_output.sv
// Directed bench: one DUT with a long watchdog for PWM/arming, one with a short watchdog for failsafe.
module tb_dshot_pwm_output;
   import dshot_pkg::*;

   // Scaled timing so full PWM periods fit in a short run.
   localparam int unsigned M_PERIOD  = 4200;
   localparam int unsigned M_MIN     = 100;
   localparam int unsigned M_SHIFT   = 1;
   localparam int unsigned M_TIMEOUT = 1000000;
   localparam int unsigned W_PERIOD  = 1200;
   localparam int unsigned W_MIN     = 50;
   localparam int unsigned W_SHIFT   = 0;
   localparam int unsigned W_TIMEOUT = 2000;
   localparam int unsigned ARM       = 10;

   logic   clk = 1'b0;
   logic   rst;
   logic   m_pwm, m_armed, m_fs;
   pulse_t m_pulse;
   logic   w_pwm, w_armed, w_fs;
   pulse_t w_pulse;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   dshot_pwm_output_if fif();

   dshot_pwm_output #(
      .PERIOD_CLKS(M_PERIOD), .MIN_PULSE_CLKS(M_MIN), .STEP_SHIFT(M_SHIFT),
      .ARM_FRAMES(ARM), .TIMEOUT_CLKS(M_TIMEOUT)
   ) dut (
      .clk(clk), .rst(rst), .frame(fif),
      .pwmOut(m_pwm), .pulseClks(m_pulse), .armed(m_armed), .failsafe(m_fs)
   );

   dshot_pwm_output #(
      .PERIOD_CLKS(W_PERIOD), .MIN_PULSE_CLKS(W_MIN), .STEP_SHIFT(W_SHIFT),
      .ARM_FRAMES(ARM), .TIMEOUT_CLKS(W_TIMEOUT)
   ) dut_wd (
      .clk(clk), .rst(rst), .frame(fif),
      .pwmOut(w_pwm), .pulseClks(w_pulse), .armed(w_armed), .failsafe(w_fs)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      repeat (n) step();
   endtask

   // processing high for one clock, then falls with the decoded fields valid (strobe cycle).
   task automatic send_frame(input logic [10:0] speed, input logic [5:0] cmd,
                             input logic is_cmd, input logic is_spd, input logic crc);
      fif.processing = 1'b1;
      step();
      fif.processing       = 1'b0;
      fif.setSpeed         = speed;
      fif.specialCommand   = cmd;
      fif.isSpecialCommand = is_cmd;
      fif.isValidSpeed     = is_spd;
      fif.CRCValid         = crc;
      step();
      fif.setSpeed         = '0;
      fif.specialCommand   = '0;
      fif.isSpecialCommand = 1'b0;
      fif.isValidSpeed     = 1'b0;
      fif.CRCValid         = 1'b0;
   endtask

   task automatic send_disarm();
      send_frame(11'd0, 6'd0, 1'b1, 1'b0, 1'b1);
   endtask

   task automatic send_throttle(input logic [10:0] speed);
      send_frame(speed, 6'd0, 1'b0, 1'b1, 1'b1);
   endtask

   function automatic logic pwm_of(input bit use_wd);
      return use_wd ? w_pwm : m_pwm;
   endfunction

   function automatic int pulse_of(input bit use_wd);
      return use_wd ? int'(w_pulse) : int'(m_pulse);
   endfunction

   // Finds the next rising edge and counts high clocks of that pulse.
   task automatic measure(input bit use_wd, output int width, output int loaded,
                          output bit timed_out);
      int n;
      timed_out = 1'b0;
      width     = 0;
      n = 0;
      while (pwm_of(use_wd) == 1'b1 && n < 5000) begin step(); n++; end
      n = 0;
      while (pwm_of(use_wd) == 1'b0 && n < 5000) begin step(); n++; end
      if (n >= 5000) timed_out = 1'b1;
      loaded = pulse_of(use_wd);
      while (pwm_of(use_wd) == 1'b1 && width < 5000) begin width++; step(); end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      idle(3);
      total++; if (m_pwm !== 1'b0) begin bad++; $display("FAIL reset_pwm: got %0b want 0", m_pwm); end
      total++; if (m_pulse !== 16'd100) begin bad++; $display("FAIL reset_pulse: got %0d want 100", m_pulse); end
      total++; if (m_armed !== 1'b0 || m_fs !== 1'b0) begin bad++; $display("FAIL reset_flags: armed=%0b failsafe=%0b want 0 0", m_armed, m_fs); end
      total++; if (w_pulse !== 16'd50) begin bad++; $display("FAIL reset_wd_pulse: got %0d want 50", w_pulse); end
      rst = 1'b0;
      step();
      total++; if (m_pwm !== 1'b1) begin bad++; $display("FAIL first_clock_high: got %0b want 1", m_pwm); end
      idle(49);
      #2 rst = 1'b1;
      #1;
      total++; if (m_pwm !== 1'b0 || w_pwm !== 1'b0) begin bad++; $display("FAIL midpulse_reset: pwm=%0b wd_pwm=%0b want 0 0", m_pwm, w_pwm); end
      step();
      rst = 1'b0;
      idle(100);
      total++; if (m_pwm !== 1'b1) begin bad++; $display("FAIL first_pulse_last_clock: got %0b want 1", m_pwm); end
      step();
      total++; if (m_pwm !== 1'b0) begin bad++; $display("FAIL first_pulse_width: got %0b want 0 after 100 clocks", m_pwm); end
   endtask

   task automatic test_arm_restart();
      repeat (5) send_disarm();
      send_throttle(11'd500);
      total++; if (m_armed !== 1'b0) begin bad++; $display("FAIL arm_after_throttle: got %0b want 0", m_armed); end
      repeat (ARM - 1) send_disarm();
      total++; if (m_armed !== 1'b0 || w_armed !== 1'b0) begin bad++; $display("FAIL arm_nine_frames: armed=%0b wd_armed=%0b want 0 0", m_armed, w_armed); end
      send_disarm();
      total++; if (m_armed !== 1'b1 || w_armed !== 1'b1) begin bad++; $display("FAIL arm_tenth_frame: armed=%0b wd_armed=%0b want 1 1", m_armed, w_armed); end
      total++; if (m_fs !== 1'b0) begin bad++; $display("FAIL arm_failsafe: got %0b want 0", m_fs); end
   endtask

   task automatic test_throttle();
      int w, ld; bit to;
      send_throttle(11'd1047);
      measure(1'b0, w, ld, to);
      total++; if (to || ld != 2098 || w != 2098) begin bad++; $display("FAIL throttle_1047: loaded=%0d width=%0d timeout=%0b want 2098 2098", ld, w, to); end
      send_throttle(11'd2047);
      measure(1'b0, w, ld, to);
      total++; if (to || ld != 4098 || w != 4098) begin bad++; $display("FAIL throttle_2047: loaded=%0d width=%0d timeout=%0b want 4098 4098", ld, w, to); end
      send_throttle(11'd48);
      measure(1'b0, w, ld, to);
      total++; if (to || ld != 100 || w != 100) begin bad++; $display("FAIL throttle_48: loaded=%0d width=%0d timeout=%0b want 100 100", ld, w, to); end
   endtask

   task automatic test_bad_crc();
      int w, ld; bit to;
      send_frame(11'd2047, 6'd0, 1'b0, 1'b1, 1'b0);
      measure(1'b0, w, ld, to);
      total++; if (to || ld != 100 || w != 100) begin bad++; $display("FAIL bad_crc_ignored: loaded=%0d width=%0d timeout=%0b want 100 100", ld, w, to); end
      total++; if (m_armed !== 1'b1) begin bad++; $display("FAIL bad_crc_armed: got %0b want 1", m_armed); end
   endtask

   task automatic test_failsafe_rearm();
      total++; if (w_fs !== 1'b1 || w_armed !== 1'b0) begin bad++; $display("FAIL wd_in_failsafe: failsafe=%0b armed=%0b want 1 0", w_fs, w_armed); end
      repeat (ARM - 1) send_disarm();
      total++; if (w_fs !== 1'b1 || w_armed !== 1'b0) begin bad++; $display("FAIL rearm_nine: failsafe=%0b armed=%0b want 1 0", w_fs, w_armed); end
      send_disarm();
      total++; if (w_fs !== 1'b0 || w_armed !== 1'b1) begin bad++; $display("FAIL rearm_tenth: failsafe=%0b armed=%0b want 0 1", w_fs, w_armed); end
      total++; if (m_armed !== 1'b1) begin bad++; $display("FAIL disarm_cmd_stays_armed: got %0b want 1", m_armed); end
   endtask

   task automatic test_wd_timeout();
      idle(1000);
      send_frame(11'd2047, 6'd0, 1'b0, 1'b1, 1'b0);
      idle(997);
      total++; if (w_fs !== 1'b0 || w_armed !== 1'b1) begin bad++; $display("FAIL wd_before_expiry: failsafe=%0b armed=%0b want 0 1", w_fs, w_armed); end
      step();
      total++; if (w_fs !== 1'b1 || w_armed !== 1'b0) begin bad++; $display("FAIL wd_expiry: failsafe=%0b armed=%0b want 1 0", w_fs, w_armed); end
   endtask

   task automatic test_wd_race();
      repeat (ARM) send_disarm();
      total++; if (w_armed !== 1'b1) begin bad++; $display("FAIL race_rearm: got %0b want 1", w_armed); end
      idle(1998);
      send_frame(11'd0, 6'd5, 1'b1, 1'b0, 1'b1);
      total++; if (w_fs !== 1'b0 || w_armed !== 1'b1) begin bad++; $display("FAIL wd_race_frame_wins: failsafe=%0b armed=%0b want 0 1", w_fs, w_armed); end
   endtask

   task automatic test_failsafe_no_cut();
      int w, ld, n; bit to;
      n = 0;
      while (w_pwm == 1'b1 && n < 1300) begin step(); n++; end
      n = 0;
      while (w_pwm == 1'b0 && n < 1300) begin step(); n++; end
      total++; if (n >= 1300) begin bad++; $display("FAIL align_timeout: got %0d clocks want < 1300", n); end
      send_throttle(11'd1047);
      measure(1'b1, w, ld, to);
      total++; if (to || ld != 1049 || w != 1049) begin bad++; $display("FAIL failsafe_no_cut: loaded=%0d width=%0d timeout=%0b want 1049 1049", ld, w, to); end
      total++; if (w_fs !== 1'b1 || w_armed !== 1'b0) begin bad++; $display("FAIL failsafe_mid_pulse: failsafe=%0b armed=%0b want 1 0", w_fs, w_armed); end
      measure(1'b1, w, ld, to);
      total++; if (to || ld != 50 || w != 50) begin bad++; $display("FAIL failsafe_next_min: loaded=%0d width=%0d timeout=%0b want 50 50", ld, w, to); end
   endtask

   initial begin
      fif.processing       = 1'b0;
      fif.setSpeed         = '0;
      fif.specialCommand   = '0;
      fif.isSpecialCommand = 1'b0;
      fif.isValidSpeed     = 1'b0;
      fif.CRCValid         = 1'b0;
      rst                  = 1'b1;
      test_reset();
      test_arm_restart();
      test_throttle();
      test_bad_crc();
      test_failsafe_rearm();
      test_wd_timeout();
      test_wd_race();
      test_failsafe_no_cut();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #3000000;
      $display("FAIL global_timeout: simulation did not complete, total=%0d bad=%0d", total, bad);
      $fatal(1, "timeout");
   end

endmodule
